// File: rtl/mailbox_core.sv
// mailbox_core: dual-port 32-bit mailbox between a port-B bus bridge and
// on-chip port-A logic.
//   Word 0 = db_b2a doorbell (B sets, A write-1-to-clears) -> o_irq_a
//   Word 1 = db_a2b doorbell (A sets, B write-1-to-clears) -> o_irq_b
//   Words 2..DEPTH-1 = plain shared storage (not reset)
// Ports:
//   i_clk, i_rst_n            clock, async active-low reset
//   mailbox_*_portb           port-B write/read strobes, byte addrs, data
//   mailbox_ren_dout_vld/...  port-B read response, 1-cycle latency
//   porta_*                   port-A write/read strobes and read response
//   o_irq_a / o_irq_b         doorbell-nonzero interrupts (registered)
//   o_err_cnt                 saturating count of out-of-range accesses
module mailbox_core #(
  parameter int DEPTH_LOG2 = 6,
  parameter int ADDR_LSB   = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        mailbox_wen_portb,
  input  logic [31:0] mailbox_wen_addr_portb,
  input  logic [31:0] mailbox_wen_din_portb,
  input  logic        mailbox_ren_portb,
  input  logic [31:0] mailbox_ren_addr_portb,
  output logic        mailbox_ren_dout_vld,
  output logic [31:0] mailbox_ren_dout_portb,
  input  logic        porta_wen,
  input  logic [31:0] porta_waddr,
  input  logic [31:0] porta_wdata,
  input  logic        porta_ren,
  input  logic [31:0] porta_raddr,
  output logic        porta_rvld,
  output logic [31:0] porta_rdata,
  output logic        o_irq_a,
  output logic        o_irq_b,
  output logic [15:0] o_err_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int HI    = ADDR_LSB + DEPTH_LOG2;

  typedef logic [DEPTH_LOG2-1:0] idx_t;

  // Any set bit above the word-index field makes the access out of range.
  function automatic logic is_oor(input logic [31:0] a);
    return |(a >> HI);
  endfunction

  function automatic idx_t widx(input logic [31:0] a);
    return a[ADDR_LSB +: DEPTH_LOG2];
  endfunction

  // Byte-offset bits below ADDR_LSB are ignored by design.
  logic unused_low_bits;
  assign unused_low_bits = ^{mailbox_wen_addr_portb[ADDR_LSB-1:0], mailbox_ren_addr_portb[ADDR_LSB-1:0],
                             porta_waddr[ADDR_LSB-1:0], porta_raddr[ADDR_LSB-1:0]};

  logic [31:0] mem [DEPTH];

  logic        b_w_oor, b_r_oor, a_w_oor, a_r_oor;
  logic        b_w_ok, a_w_ok;
  idx_t        b_w_idx, b_r_idx, a_w_idx, a_r_idx;

  logic [31:0] db_b2a_q, db_b2a_d, db_a2b_q, db_a2b_d;
  logic        irq_a_q, irq_a_d, irq_b_q, irq_b_d;
  logic [15:0] err_q, err_d;
  logic        b_vld_q, b_vld_d, a_vld_q, a_vld_d;
  logic [31:0] b_rdata_q, b_rdata_d, a_rdata_q, a_rdata_d;
  logic [2:0]  err_inc;
  logic [16:0] err_sum;

  always_comb begin
    b_w_oor = mailbox_wen_portb & is_oor(mailbox_wen_addr_portb);
    b_r_oor = mailbox_ren_portb & is_oor(mailbox_ren_addr_portb);
    a_w_oor = porta_wen & is_oor(porta_waddr);
    a_r_oor = porta_ren & is_oor(porta_raddr);
    b_w_ok  = mailbox_wen_portb & ~b_w_oor;
    a_w_ok  = porta_wen & ~a_w_oor;
    b_w_idx = widx(mailbox_wen_addr_portb);
    b_r_idx = widx(mailbox_ren_addr_portb);
    a_w_idx = widx(porta_waddr);
    a_r_idx = widx(porta_raddr);
  end

  // Doorbells: clear applied before set so a simultaneous set wins per bit.
  always_comb begin
    db_b2a_d = db_b2a_q;
    if (a_w_ok && a_w_idx == idx_t'(0)) db_b2a_d = db_b2a_d & ~porta_wdata;
    if (b_w_ok && b_w_idx == idx_t'(0)) db_b2a_d = db_b2a_d | mailbox_wen_din_portb;
    db_a2b_d = db_a2b_q;
    if (b_w_ok && b_w_idx == idx_t'(1)) db_a2b_d = db_a2b_d & ~mailbox_wen_din_portb;
    if (a_w_ok && a_w_idx == idx_t'(1)) db_a2b_d = db_a2b_d | porta_wdata;
    // Registering the OR of the next value gives irq the same timing as db_q.
    irq_a_d = |db_b2a_d;
    irq_b_d = |db_a2b_d;
  end

  // Every out-of-range strobe counts, up to four per cycle; saturate.
  always_comb begin
    err_inc = {2'b00, b_w_oor} + {2'b00, b_r_oor} + {2'b00, a_w_oor} + {2'b00, a_r_oor};
    err_sum = {1'b0, err_q} + {14'b0, err_inc};
    err_d   = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  // Read muxes sample current state, so same-cycle writes read old data.
  always_comb begin
    b_vld_d   = mailbox_ren_portb;
    b_rdata_d = b_rdata_q;
    if (mailbox_ren_portb) begin
      if (b_r_oor)                     b_rdata_d = 32'h0;
      else if (b_r_idx == idx_t'(0))   b_rdata_d = db_b2a_q;
      else if (b_r_idx == idx_t'(1))   b_rdata_d = db_a2b_q;
      else                             b_rdata_d = mem[b_r_idx];
    end
    a_vld_d   = porta_ren;
    a_rdata_d = a_rdata_q;
    if (porta_ren) begin
      if (a_r_oor)                     a_rdata_d = 32'h0;
      else if (a_r_idx == idx_t'(0))   a_rdata_d = db_b2a_q;
      else if (a_r_idx == idx_t'(1))   a_rdata_d = db_a2b_q;
      else                             a_rdata_d = mem[a_r_idx];
    end
  end

  // Storage is intentionally unreset. Port B is written last so it wins
  // when both ports hit the same word.
  always_ff @(posedge i_clk) begin
    if (a_w_ok && a_w_idx > idx_t'(1)) mem[a_w_idx] <= porta_wdata;
    if (b_w_ok && b_w_idx > idx_t'(1)) mem[b_w_idx] <= mailbox_wen_din_portb;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      db_b2a_q  <= '0;
      db_a2b_q  <= '0;
      irq_a_q   <= 1'b0;
      irq_b_q   <= 1'b0;
      err_q     <= '0;
      b_vld_q   <= 1'b0;
      a_vld_q   <= 1'b0;
      b_rdata_q <= '0;
      a_rdata_q <= '0;
    end else begin
      db_b2a_q  <= db_b2a_d;
      db_a2b_q  <= db_a2b_d;
      irq_a_q   <= irq_a_d;
      irq_b_q   <= irq_b_d;
      err_q     <= err_d;
      b_vld_q   <= b_vld_d;
      a_vld_q   <= a_vld_d;
      b_rdata_q <= b_rdata_d;
      a_rdata_q <= a_rdata_d;
    end
  end

  assign mailbox_ren_dout_vld   = b_vld_q;
  assign mailbox_ren_dout_portb = b_rdata_q;
  assign porta_rvld             = a_vld_q;
  assign porta_rdata            = a_rdata_q;
  assign o_irq_a                = irq_a_q;
  assign o_irq_b                = irq_b_q;
  assign o_err_cnt              = err_q;

endmodule

// File: tb/tb_mailbox_core.sv
// Directed self-checking bench for mailbox_core. Inputs change 1ns after
// each rising edge; outputs are checked at the same point, so a strobe
// driven before edge N is checked right after edge N.
module tb_mailbox_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        b_wen, b_ren, a_wen, a_ren;
  logic [31:0] b_waddr, b_wdata, b_raddr, a_waddr, a_wdata, a_raddr;
  logic        b_vld, a_vld, irq_a, irq_b;
  logic [31:0] b_rdata, a_rdata;
  logic [15:0] err_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mailbox_core dut (
    .i_clk                  (clk),
    .i_rst_n                (rst_n),
    .mailbox_wen_portb      (b_wen),
    .mailbox_wen_addr_portb (b_waddr),
    .mailbox_wen_din_portb  (b_wdata),
    .mailbox_ren_portb      (b_ren),
    .mailbox_ren_addr_portb (b_raddr),
    .mailbox_ren_dout_vld   (b_vld),
    .mailbox_ren_dout_portb (b_rdata),
    .porta_wen              (a_wen),
    .porta_waddr            (a_waddr),
    .porta_wdata            (a_wdata),
    .porta_ren              (a_ren),
    .porta_raddr            (a_raddr),
    .porta_rvld             (a_vld),
    .porta_rdata            (a_rdata),
    .o_irq_a                (irq_a),
    .o_irq_b                (irq_b),
    .o_err_cnt              (err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    b_wen = 0; b_ren = 0; a_wen = 0; a_ren = 0;
    b_waddr = 0; b_wdata = 0; b_raddr = 0; a_waddr = 0; a_wdata = 0; a_raddr = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic bw(input logic [31:0] ad, input logic [31:0] d);
    b_wen = 1; b_waddr = ad; b_wdata = d;
  endtask

  task automatic aw(input logic [31:0] ad, input logic [31:0] d);
    a_wen = 1; a_waddr = ad; a_wdata = d;
  endtask

  task automatic br(input logic [31:0] ad);
    b_ren = 1; b_raddr = ad;
  endtask

  task automatic ar(input logic [31:0] ad);
    a_ren = 1; a_raddr = ad;
  endtask

  initial begin
    idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_b_vld", b_vld, 0);
    chk("rst_a_vld", a_vld, 0);
    chk("rst_irq", {irq_a, irq_b}, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_b_data", b_rdata, 0);
    rst_n = 1;
    tick();

    // Basic B write, A read.
    bw(32'h14, 32'hA5A5_0001); tick(); idle();
    ar(32'h14); tick(); idle();
    chk("a_rd_vld", a_vld, 1);
    chk("a_rd_data", a_rdata, 32'hA5A5_0001);
    tick();
    chk("a_rd_vld_single", a_vld, 0);

    // db_b2a set / partial clear / full clear.
    bw(32'h0, 32'h3); tick(); idle();
    chk("irq_a_set", irq_a, 1);
    chk("irq_b_quiet", irq_b, 0);
    aw(32'h0, 32'h1); tick(); idle();
    chk("irq_a_partial", irq_a, 1);
    ar(32'h0); tick(); idle();
    chk("db_b2a_0x2", a_rdata, 32'h2);
    aw(32'h0, 32'h2); tick(); idle();
    chk("irq_a_clr", irq_a, 0);

    // Simultaneous set and clear on the same bit: set wins.
    bw(32'h0, 32'h4); aw(32'h0, 32'h4); tick(); idle();
    chk("irq_a_setwins", irq_a, 1);
    br(32'h0); tick(); idle();
    chk("db_b2a_0x4", b_rdata, 32'h4);
    aw(32'h0, 32'h4); tick(); idle();
    chk("irq_a_clr2", irq_a, 0);

    // Both ports write word 3: B wins.
    bw(32'h0C, 32'h11); aw(32'h0C, 32'h22); tick(); idle();
    br(32'h0C); tick(); idle();
    chk("word3_bwins", b_rdata, 32'h11);

    // db_a2b: A sets, B clears.
    aw(32'h4, 32'h80); tick(); idle();
    chk("irq_b_set", irq_b, 1);
    br(32'h4); tick(); idle();
    chk("db_a2b_rd", b_rdata, 32'h80);
    bw(32'h4, 32'h80); tick(); idle();
    chk("irq_b_clr", irq_b, 0);

    // Preload words 2..9 then stream reads back-to-back.
    for (int i = 0; i < 8; i++) begin
      bw(32'h08 + 32'(4 * i), 32'h1000 + 32'(i)); tick();
    end
    idle();
    for (int i = 0; i < 8; i++) begin
      br(32'h08 + 32'(4 * i)); tick();
      chk($sformatf("stream_vld%0d", i), b_vld, 1);
      chk($sformatf("stream_data%0d", i), b_rdata, 32'h1000 + 32'(i));
    end
    idle(); tick();
    chk("stream_vld_end", b_vld, 0);

    // Read-first across ports.
    bw(32'h1C, 32'h55); tick(); idle();
    br(32'h1C); aw(32'h1C, 32'h66); tick(); idle();
    chk("rdw_old", b_rdata, 32'h55);
    br(32'h1C); tick(); idle();
    chk("rdw_new", b_rdata, 32'h66);

    // Low byte-offset bits ignored: 0x17 -> word 5 (preloaded 0x1003).
    ar(32'h17); tick(); idle();
    chk("low_bits_ign", a_rdata, 32'h1003);

    // Out-of-range accesses.
    chk("err_zero", err_cnt, 0);
    br(32'h100); tick(); idle();
    chk("oor_rd_vld", b_vld, 1);
    chk("oor_rd_data", b_rdata, 0);
    bw(32'h200, 32'hDEAD_BEEF); tick(); idle();
    chk("oor_wr_no_irq", irq_a, 0);
    chk("err_two", err_cnt, 2);
    br(32'h0); tick(); idle();
    chk("oor_wr_dropped", b_rdata, 0);
    ar(32'h400); bw(32'h300, 32'h1); tick(); idle();
    chk("err_both_ports", err_cnt, 4);

    // Saturation: four out-of-range strobes per cycle.
    for (int i = 0; i < 16383; i++) begin
      bw(32'h100, 0); br(32'h100); aw(32'h100, 0); ar(32'h100); tick();
    end
    chk("err_sat", err_cnt, 16'hFFFF);
    tick(); idle();
    chk("err_sat_hold", err_cnt, 16'hFFFF);

    // Mid-operation reset with irq high and a read in flight.
    bw(32'h0, 32'h1); tick(); idle();
    br(32'h1C); tick();
    chk("pre_rst_vld", b_vld, 1);
    #2 rst_n = 0;
    #1;
    chk("async_vld", b_vld, 0);
    chk("async_data", b_rdata, 0);
    chk("async_irq_a", irq_a, 0);
    chk("async_err", err_cnt, 0);
    idle();
    tick();
    rst_n = 1;
    tick();
    br(32'h1C); tick(); idle();
    chk("mem_kept", b_rdata, 32'h66);
    br(32'h0); tick(); idle();
    chk("db_cleared", b_rdata, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
